// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clk_div_bank divider slice.
`timescale 1ns/1ps
package clk_div_pkg;

  localparam int DIV_W_DEF = 16;
  localparam int MIN_DIV   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } ch_state_e;

endpackage

// File: rtl/clk_div_bank_if.sv
// Control/status bundle between a divider bank and its user.
// sync_i exists only when CLK_DIV_SYNC_EN is defined.
`timescale 1ns/1ps
interface clk_div_bank_if #(
  parameter int N_CH  = 4,
  parameter int DIV_W = 16
);

  logic [N_CH*DIV_W-1:0] divisor_bus;
  logic [N_CH-1:0]       ch_en;
`ifdef CLK_DIV_SYNC_EN
  logic                  sync_i;
`endif
  logic [N_CH-1:0]       slow_clk;
  logic [N_CH-1:0]       tick;
  logic [N_CH-1:0]       div_err;

  modport master (
`ifdef CLK_DIV_SYNC_EN
    output sync_i,
`endif
    output divisor_bus, ch_en,
    input  slow_clk, tick, div_err
  );

  modport slave (
`ifdef CLK_DIV_SYNC_EN
    input  sync_i,
`endif
    input  divisor_bus, ch_en,
    output slow_clk, tick, div_err
  );

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: IDLE/RUN/ERR state machine, period counter,
// shadowed divisor and registered slow_clk/tick/div_err outputs.
// A new divisor is only adopted at the wrap edge (or on a sync strobe),
// so a period already in progress always completes with its old length.
`timescale 1ns/1ps
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             chosen_clk,
  input  logic             i_wb_rst_n,
  input  logic [DIV_W-1:0] i_divisor,
  input  logic             i_en,
  input  logic             i_sync,
  output logic             o_slow_clk,
  output logic             o_tick,
  output logic             o_div_err
);

  localparam logic [DIV_W-1:0] MIN_D = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] ONE_D = DIV_W'(1);

  ch_state_e        r_state;
  ch_state_e        w_state_nxt;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] r_act_div;
  logic [DIV_W-1:0] w_act_div_nxt;
  logic             r_slow;
  logic             w_slow_nxt;
  logic             r_tick;
  logic             w_tick_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic             w_div_ok;
  logic             w_at_rise;
  logic             w_at_wrap;
  logic             w_reload;

  // In RUN act_div >= 2, so act_div-1 cannot underflow; (D-1)>>1 equals
  // ceil(D/2)-1 without needing an extra bit for D = 2^DIV_W-1.
  assign w_div_ok  = (i_divisor >= MIN_D);
  assign w_at_rise = (r_cnt == ((r_act_div - ONE_D) >> 1));
  assign w_at_wrap = (r_cnt == (r_act_div - ONE_D));
  assign w_reload  = i_sync || w_at_wrap;

  // State register plus all datapath flops; outputs come straight from here.
  always_ff @(posedge chosen_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_act_div <= '0;
      r_slow    <= 1'b0;
      r_tick    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_act_div <= w_act_div_nxt;
      r_slow    <= w_slow_nxt;
      r_tick    <= w_tick_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Next-state selection: disable beats sync, which beats normal counting.
  always_comb begin
    w_state_nxt = r_state;
    if (!i_en) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = w_div_ok ? RUN : ERR;
        RUN:     if (w_reload && !w_div_ok) w_state_nxt = ERR;
        ERR:     if (w_div_ok) w_state_nxt = RUN;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs, counter and shadow divisor.
  always_comb begin
    w_cnt_nxt     = '0;
    w_act_div_nxt = r_act_div;
    w_slow_nxt    = 1'b0;
    w_tick_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    if (i_en) begin
      case (r_state)
        IDLE, ERR: begin
          w_act_div_nxt = i_divisor;
          w_err_nxt     = !w_div_ok;
        end
        RUN: begin
          if (w_reload) begin
            w_act_div_nxt = i_divisor;
            w_err_nxt     = !w_div_ok;
          end else begin
            w_cnt_nxt  = r_cnt + ONE_D;
            w_slow_nxt = r_slow | w_at_rise;
            w_tick_nxt = w_at_rise;
          end
        end
        default: begin
          w_act_div_nxt = '0;
        end
      endcase
    end
  end

  assign o_slow_clk = r_slow;
  assign o_tick     = r_tick;
  assign o_div_err  = r_err;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of N_CH independent programmable clock dividers with per-rise ticks.
// Optional phase-align strobe sync_i is built in when CLK_DIV_SYNC_EN is defined.
`timescale 1ns/1ps
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic         chosen_clk,
  input  logic         i_wb_rst_n,
  clk_div_bank_if.slave bus
);

  logic            w_sync;
  logic [N_CH-1:0] w_slow;
  logic [N_CH-1:0] w_tick;
  logic [N_CH-1:0] w_err;

`ifdef CLK_DIV_SYNC_EN
  assign w_sync = bus.sync_i;
`else
  assign w_sync = 1'b0;
`endif

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    clk_div_ch #(
      .DIV_W (DIV_W)
    ) u_ch (
      .chosen_clk (chosen_clk),
      .i_wb_rst_n (i_wb_rst_n),
      .i_divisor  (bus.divisor_bus[k*DIV_W +: DIV_W]),
      .i_en       (bus.ch_en[k]),
      .i_sync     (w_sync),
      .o_slow_clk (w_slow[k]),
      .o_tick     (w_tick[k]),
      .o_div_err  (w_err[k])
    );
  end

  assign bus.slow_clk = w_slow;
  assign bus.tick     = w_tick;
  assign bus.div_err  = w_err;

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank; sync tests built with CLK_DIV_SYNC_EN.
`timescale 1ns/1ps
module tb_clk_div_bank;

  localparam int N_CH  = 4;
  localparam int DIV_W = 16;

  logic chosen_clk = 1'b0;
  logic i_wb_rst_n = 1'b0;

  clk_div_bank_if #(.N_CH(N_CH), .DIV_W(DIV_W)) bus ();

  clk_div_bank #(.N_CH(N_CH), .DIV_W(DIV_W)) dut (
    .chosen_clk (chosen_clk),
    .i_wb_rst_n (i_wb_rst_n),
    .bus        (bus)
  );

  // Free-running 100 MHz source clock
  always #5 chosen_clk = ~chosen_clk;

  // Count active edges so expectations can be expressed as edge numbers
  int cyc = 0;
  always @(posedge chosen_clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  // Expected slow_clk transition edges, one queue per channel
  int expQ [N_CH][$];
  logic [N_CH-1:0] prevSlow = '0;
  bit monEn = 1'b0;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Every transition of slow_clk must match the next scheduled edge; tick must mark rises
  always @(negedge chosen_clk) begin
    if (monEn) begin
      for (int k = 0; k < N_CH; k++) begin
        if (bus.slow_clk[k] != prevSlow[k]) begin
          if (expQ[k].size() == 0)
            checkOutput($sformatf("unexpected edge ch%0d", k), cyc, -1);
          else
            checkOutput($sformatf("edge ch%0d", k), cyc, expQ[k].pop_front());
        end
        checkOutput($sformatf("tick ch%0d", k), int'(bus.tick[k]),
                    int'(bus.slow_clk[k] && !prevSlow[k]));
      end
    end
    prevSlow <= bus.slow_clk;
  end

  // Push expected transitions for a stretch that starts with cnt=0, slow low,
  // after edge 'start', and ends at edge 'stop' where slow is forced low.
  task automatic schedule(input int k, input int start, input int d, input int stop);
    int h;
    int p;
    bit high;
    h = (d + 1) / 2;
    high = 1'b0;
    for (int t = start + 1; t < stop; t++) begin
      p = (t - start) % d;
      if (p == h) begin
        expQ[k].push_back(t);
        high = 1'b1;
      end else if (p == 0) begin
        expQ[k].push_back(t);
        high = 1'b0;
      end
    end
    if (high) expQ[k].push_back(stop);
  endtask

  task automatic setDiv(input int k, input int d);
    bus.divisor_bus[k*DIV_W +: DIV_W] = DIV_W'(d);
  endtask

  task automatic waitTo(input int c);
    while (cyc < c) @(negedge chosen_clk);
  endtask

  task automatic checkQueues(input string tag);
    for (int k = 0; k < N_CH; k++) begin
      checkOutput($sformatf("%s pending ch%0d", tag, k), expQ[k].size(), 0);
      expQ[k].delete();
    end
  endtask

  // Drive a new enable vector at a falling edge; returns the edge where it is seen
  task automatic applyStimulus(input logic [N_CH-1:0] en, output int loadEdge);
    bus.ch_en = en;
    loadEdge = cyc + 1;
  endtask

  // Stop the run if something wedges the sequence
  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence
  initial begin
    int e;
    int f;
    int g;
    int s;
    int divs [N_CH];
    int offs [N_CH];

    bus.ch_en = '1;
    for (int k = 0; k < N_CH; k++) setDiv(k, 4);
`ifdef CLK_DIV_SYNC_EN
    bus.sync_i = 1'b0;
`endif
    i_wb_rst_n = 1'b0;

    repeat (10) @(negedge chosen_clk);
    checkOutput("rst slow early", int'(bus.slow_clk), 0);
    repeat (20) @(negedge chosen_clk);
    checkOutput("rst slow", int'(bus.slow_clk), 0);
    checkOutput("rst tick", int'(bus.tick), 0);
    checkOutput("rst div_err", int'(bus.div_err), 0);
    bus.ch_en = '0;
    @(negedge chosen_clk);
    i_wb_rst_n = 1'b1;
    repeat (3) @(negedge chosen_clk);
    checkOutput("post-rst idle slow", int'(bus.slow_clk), 0);
    checkOutput("post-rst idle err", int'(bus.div_err), 0);
    monEn = 1'b1;

    $display("[TB] concurrent channels");
    divs = '{4, 5, 100, 101};
    for (int k = 0; k < N_CH; k++) setDiv(k, divs[k]);
    applyStimulus('1, e);
    f = e + 1012;
    for (int k = 0; k < N_CH; k++) schedule(k, e, divs[k], f);
    waitTo(f - 1);
    applyStimulus('0, g);
    waitTo(f + 2);
    checkQueues("concurrent");

    $display("[TB] shadow divisor update");
    setDiv(0, 4);
    applyStimulus(4'b0001, e);
    schedule(0, e, 4, e + 4);
    waitTo(e + 1);
    setDiv(0, 10);
    f = e + 35;
    schedule(0, e + 4, 10, f);
    waitTo(f - 1);
    applyStimulus('0, g);
    waitTo(f + 2);
    checkQueues("shadow");

    $display("[TB] invalid divisor");
    setDiv(1, 0);
    applyStimulus(4'b0010, e);
    waitTo(e + 3);
    checkOutput("err D=0", int'(bus.div_err), 2);
    checkOutput("err D=0 slow", int'(bus.slow_clk), 0);
    setDiv(1, 1);
    waitTo(e + 8);
    checkOutput("err D=1", int'(bus.div_err), 2);
    setDiv(1, 6);
    g = cyc + 1;
    schedule(1, g, 6, g + 20);
    waitTo(g);
    checkOutput("err cleared", int'(bus.div_err), 0);
    waitTo(g + 19);
    applyStimulus('0, f);
    waitTo(g + 22);
    checkQueues("invalid");

    $display("[TB] disable mid-high");
    setDiv(2, 100);
    applyStimulus(4'b0100, e);
    f = e + 71;
    schedule(2, e, 100, f);
    waitTo(f - 1);
    applyStimulus('0, g);
    waitTo(f);
    checkOutput("disable slow", int'(bus.slow_clk), 0);
    waitTo(f + 5);
    applyStimulus(4'b0100, g);
    schedule(2, g, 100, g + 60);
    waitTo(g + 59);
    applyStimulus('0, e);
    waitTo(g + 62);
    checkQueues("disable");

`ifdef CLK_DIV_SYNC_EN
    $display("[TB] sync strobe");
    divs = '{4, 6, 8, 12};
    offs = '{0, 1, 3, 5};
    for (int k = 0; k < N_CH; k++) setDiv(k, divs[k]);
    e = cyc + 1;
    s = e + 41;
    f = s + 40;
    for (int k = 0; k < N_CH; k++) begin
      waitTo(e + offs[k] - 1);
      bus.ch_en[k] = 1'b1;
      schedule(k, e + offs[k], divs[k], s);
    end
    waitTo(s - 1);
    bus.sync_i = 1'b1;
    for (int k = 0; k < N_CH; k++) schedule(k, s, divs[k], f);
    waitTo(s);
    bus.sync_i = 1'b0;
    checkOutput("sync slow low", int'(bus.slow_clk), 0);
    waitTo(f - 1);
    applyStimulus('0, g);
    waitTo(f + 2);
    checkQueues("sync");
`endif

    $display("[TB] maximum divisor");
    setDiv(0, 65535);
    applyStimulus(4'b0001, e);
    f = e + 65536;
    schedule(0, e, 65535, f);
    waitTo(f - 1);
    applyStimulus('0, g);
    waitTo(f + 2);
    checkQueues("maxdiv");

    $display("[TB] asynchronous reset mid-run");
    monEn = 1'b0;
    for (int k = 0; k < 3; k++) setDiv(k, 4);
    setDiv(3, 0);
    applyStimulus('1, e);
    waitTo(e + 2);
    checkOutput("pre-rst slow", int'(bus.slow_clk), 7);
    checkOutput("pre-rst tick", int'(bus.tick), 7);
    checkOutput("pre-rst err", int'(bus.div_err), 8);
    #1;
    i_wb_rst_n = 1'b0;
    #1;
    checkOutput("async rst slow", int'(bus.slow_clk), 0);
    checkOutput("async rst tick", int'(bus.tick), 0);
    checkOutput("async rst err", int'(bus.div_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Multi-channel programmable clock divider; successor to the single-channel down_clk in the PWM timer.
- Generates N_CH independent divided clocks from chosen_clk, each with its own divisor and enable.
- Also produces a one-cycle tick per divided-clock rising edge for use by downstream counters.
- Divisor updates are glitch-free: a new divisor takes effect only at a period boundary.

Parameters:
- N_CH, 4, number of divider channels (1..16)
- DIV_W, 16, divisor/counter width per channel; max divisor 2^DIV_W-1

Ports:
- chosen_clk  in  1  clock to be divided
- i_wb_rst_n  in  1  asynchronous active-low reset
- divisor_bus  in  N_CH*DIV_W  channel k divisor at bits [k*DIV_W +: DIV_W]
- ch_en  in  N_CH  per-channel run enable
- sync_i  in  1  phase-align strobe; present only with CLK_DIV_SYNC_EN
- slow_clk  out  N_CH  divided clock per channel, registered
- tick  out  N_CH  one-cycle pulse, coincident with the cycle slow_clk[k] first reads 1
- div_err  out  N_CH  high while ch_en[k]=1 and the channel's sampled divisor is <2

Behaviour:
- Reset (async assert, sync release): all per-channel registers cleared; slow_clk=0, tick=0, div_err=0, cnt=0, act_div=0, channel IDLE.
- Per-channel state machine:
  - IDLE: entered from reset or when ch_en=0.
  - Transition on an edge with ch_en=1: load act_div <= divisor; if divisor <2, go to ERR; else go to RUN with cnt=0.
- RUN, with D=act_div and H=ceil(D/2):
  - cnt increments 0..D-1, then wraps to 0.
  - Edge where cnt==H-1: slow_clk<=1, tick<=1 for one cycle.
  - Edge where cnt==D-1: slow_clk<=0, cnt<=0, act_div<=divisor (shadow reload).
  - If the reloaded divisor is <2, go to ERR instead.
- Duty cycle: low phase H cycles, high phase floor(D/2) cycles; period exactly D cycles.
  - Even D gives 50%.
  - D=5 gives 3 low, 2 high.
- First rising edge of slow_clk occurs H+1 edges after the enabling edge (load edge plus H counts).
- ERR: slow_clk=0, tick=0, cnt=0, div_err=1.
  - Divisor re-sampled every cycle; moves to RUN (cnt=0, div_err=0) on the first edge with divisor >=2.
  - ch_en=0 returns to IDLE.
- Divisor change mid-period: ignored until the wrap edge. No runt pulses; no period shorter than min(old,new).
- ch_en deassert mid-period: next edge cnt=0, slow_clk=0, tick=0, IDLE (truncated high phase is permitted).
- ch_en reassert: fresh load as from IDLE.
- Channels are fully independent; no shared counter.
- Priority per channel: reset > ch_en=0 > sync_i (if enabled) > normal count.
- Counter arithmetic is unsigned DIV_W bits. D=2^DIV_W-1 must work (cnt never exceeds D-1; no overflow).
- All outputs are driven directly from flops; no combinational paths from inputs to outputs.

Optional Feature:
- Macro: CLK_DIV_SYNC_EN.
- Defined: sync_i port exists. On an edge with sync_i=1, every channel in RUN performs:
  - act_div<=divisor, cnt<=0, slow_clk<=0, tick<=0
  - Result: all channels phase-aligned; the next rising edges occur H+1 edges later.
  - IDLE/ERR channels are unaffected.
- Undefined: sync_i port absent; channels free-run relative to their own enables.

Decomposition:
- Package clk_div_pkg:
  - DIV_W_DEF=16, MIN_DIV=2
  - Channel state enum {IDLE, RUN, ERR}, 2-bit
- Sub-module clk_div_ch: one channel (state, cnt, act_div, slow_clk, tick, div_err).
  - clk_div_bank instantiates N_CH copies in a generate loop and slices divisor_bus.
  - sync_i is fanned to all channels.

Test Plan:
- Reset: hold i_wb_rst_n=0 for 30 cycles with ch_en=all ones, divisor=4 -> slow_clk=0, tick=0, div_err=0, all cnt=0; assert reset mid-RUN -> outputs 0 immediately (asynchronous).
- Concurrent: ch0 D=4, ch1 D=5, ch2 D=100, ch3 D=101, enable together ->
  - ch0: first rise after 3 edges, 2 high / 2 low.
  - ch1: 3 low / 2 high.
  - ch2: 50/50 high/low.
  - ch3: 51 low / 50 high.
  - Exactly one tick per rise; check 10 periods each.
- Shadow update: ch0 D=4 running, write D=10 at cnt=1 -> current period completes at 4 cycles, next period 10 cycles (5/5), no runt.
- Invalid divisor: ch1 D=0, then D=1 -> div_err=1, slow_clk=0, no ticks; write D=6 -> div_err clears next edge, first rise 4 edges later.
- Disable mid-high: ch2 D=100, drop ch_en at cnt=70 -> next edge slow_clk=0, IDLE; re-enable -> first rise after 51 edges.
- CLK_DIV_SYNC_EN: channels at D=4,6,8,12 free-running with offset enables; pulse sync_i -> all slow_clk low next edge; rises at 3, 4, 5, 7 edges after sync; max divisor 65535 period verified on one channel.
